// File: rtl/wb_regfile_pkg.sv
// Shared constants and types for the Y86-64 writeback register file.
// Icode encodings, register ids and the halt FSM state.
package wb_regfile_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam int NREGS = 15;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [3:0] dst_e;
    logic [3:0] dst_m;
  } dst_t;

endpackage

// File: rtl/wb_regfile_if.sv
// W-stage bundle into the register file and decode read ports out.
// master drives the W fields and read addresses; slave is the regfile.
interface wb_regfile_if #(
  parameter int N = 64
);

  logic [3:0]   w_icode;
  logic [3:0]   w_ifun;
  logic [3:0]   w_rA;
  logic [3:0]   w_rB;
  logic         w_cnd;
  logic [N-1:0] w_valE;
  logic [N-1:0] w_valM;
  logic [3:0]   d_srcA;
  logic [3:0]   d_srcB;
  logic [N-1:0] d_rvalA;
  logic [N-1:0] d_rvalB;
  logic [3:0]   w_dstE;
  logic [3:0]   w_dstM;
  logic         halted;
  logic [N-1:0] retired;

  modport master (
    output w_icode, w_ifun, w_rA, w_rB, w_cnd,
    output w_valE, w_valM, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB, w_dstE, w_dstM,
    input  halted, retired
  );

  modport slave (
    input  w_icode, w_ifun, w_rA, w_rB, w_cnd,
    input  w_valE, w_valM, d_srcA, d_srcB,
    output d_rvalA, d_rvalB, w_dstE, w_dstM,
    output halted, retired
  );

endinterface

// File: rtl/wb_dst_decode.sv
// Destination register derivation from icode/cnd/rA/rB.
// Purely combinational; shared with the hazard unit.
module wb_dst_decode
  import wb_regfile_pkg::*;
(
  input  logic [3:0] i_icode,
  input  logic [3:0] i_rA,
  input  logic [3:0] i_rB,
  input  logic       i_cnd,
  output dst_t       o_dst
);

  always_comb begin
    o_dst.dst_e = RNONE;
    o_dst.dst_m = RNONE;
    unique case (1'b1)
      (i_icode == IRRMOVQ):
        o_dst.dst_e = i_cnd ? i_rB : RNONE;
      (i_icode == IIRMOVQ),
      (i_icode == IOPQ):
        o_dst.dst_e = i_rB;
      (i_icode == IMRMOVQ):
        o_dst.dst_m = i_rA;
      (i_icode == ICALL),
      (i_icode == IRET),
      (i_icode == IPUSHQ):
        o_dst.dst_e = RSP;
      (i_icode == IPOPQ): begin
        o_dst.dst_e = RSP;
        o_dst.dst_m = i_rA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 writeback register file: commit, read ports, halt FSM, retire count.
// Define WB_BYPASS_EN to make the read ports write-through.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int N = 64
) (
  input logic       clk,
  input logic       rst_n,
  wb_regfile_if.slave bus
);

  logic [N-1:0] r_regs [NREGS];
  logic [N-1:0] r_retired;
  state_t       r_state;
  state_t       w_state_nxt;
  dst_t         w_dst;
  logic         w_run;
  logic         w_we_e;
  logic         w_we_m;
  logic         w_retire;
  logic         w_unused_ifun;

  assign w_unused_ifun = ^bus.w_ifun;

  wb_dst_decode u_dst (
    .i_icode (bus.w_icode),
    .i_rA    (bus.w_rA),
    .i_rB    (bus.w_rB),
    .i_cnd   (bus.w_cnd),
    .o_dst   (w_dst)
  );

  assign bus.w_dstE = w_dst.dst_e;
  assign bus.w_dstM = w_dst.dst_m;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:
        if (bus.w_icode == IHALT)
          w_state_nxt = S_HALTED;
      S_HALTED: ;
      default: ;
    endcase
  end

  always_comb begin
    w_run    = (r_state == S_RUN);
    w_we_e   = w_run && (w_dst.dst_e != RNONE);
    w_we_m   = w_run && (w_dst.dst_m != RNONE);
    w_retire = w_run && (bus.w_icode != INOP);
  end

  assign bus.halted = (r_state == S_HALTED);

  // M write is issued last so popq %rsp lands valM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        r_regs[i] <= '0;
    end else begin
      if (w_we_e) r_regs[w_dst.dst_e] <= bus.w_valE;
      if (w_we_m) r_regs[w_dst.dst_m] <= bus.w_valM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + N'(1);
  end

  assign bus.retired = r_retired;

  function automatic logic [N-1:0] rd_port(
    input logic [3:0] a
  );
`ifdef WB_BYPASS_EN
    if (w_we_m && a == w_dst.dst_m) return bus.w_valM;
    if (w_we_e && a == w_dst.dst_e) return bus.w_valE;
`endif
    if (a == RNONE) return '0;
    return r_regs[a];
  endfunction

  always_comb begin
    bus.d_rvalA = rd_port(bus.d_srcA);
    bus.d_rvalB = rd_port(bus.d_srcB);
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side register file for the 64-bit Y86-64 pipeline. Consumes the W-stage fields latched by the writeback pipeline register, derives destination registers from the instruction code, and commits valE/valM into fifteen program registers. Provides two combinational read ports to decode, a halt state machine and a retired-instruction counter. Sits at the far end of the M→W pipeline register, closing the loop back to decode.

## Interface
- n, 64, datapath width

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- w_icode  input  4  W-stage instruction code
- w_ifun  input  4  W-stage function code
- w_rA  input  4  W-stage rA field
- w_rB  input  4  W-stage rB field
- w_cnd  input  1  W-stage condition (cmovXX taken)
- w_valE  input  n  ALU result
- w_valM  input  n  memory read result
- d_srcA  input  4  decode read address A (0xF = none)
- d_srcB  input  4  decode read address B (0xF = none)
- d_rvalA  output  n  register value at d_srcA
- d_rvalB  output  n  register value at d_srcB
- w_dstE  output  4  derived E destination (combinational)
- w_dstM  output  4  derived M destination (combinational)
- halted  output  1  processor halted
- retired  output  n  count of retired non-bubble instructions

## Operation
- dstE: icode 2 (rrmovq/cmovXX) → rB if w_cnd else 0xF; icode 3, 6 → rB; icode 8, 9, A, B → RSP (4); else 0xF.
- dstM: icode 5, B → rA; else 0xF.
- E write: reg[dstE] ← w_valE when dstE ≠ 0xF. M write: reg[dstM] ← w_valM when dstM ≠ 0xF.
- Same destination for both (popq %rsp): M write wins; register gets w_valM.
- FSM states: RUN, HALTED. RUN→HALTED on edge where w_icode = 0. HALTED is sticky until reset. Halt instruction writes nothing.
- In HALTED: all register writes and counter increments suppressed.
- retired increments by 1 per edge in RUN when w_icode ≠ 1 (nop/bubble excluded); the halt instruction itself counts. Wraps modulo 2^n.
- Reads: address 0xF → 0; otherwise reg[addr].
- icode values above 0xB: no writes, counted as retired.

## Timing
- Reset (async, immediate): all 15 registers 0, FSM RUN, halted 0, retired 0; d_rvalA/B read 0.
- Write latency: value committed at rising edge; visible on read ports the following cycle (without bypass).
- halted asserts in the cycle after the halt edge.
- w_dstE/w_dstM purely combinational from the current W inputs.
- Reset asserted mid-run discards any write at that edge; first write after deassertion occurs on the first rising edge with rst_n high.

## Configuration
- WB_BYPASS_EN defined: read ports are write-through; if d_srcX equals an active dstM (priority) or dstE in the same cycle, d_rvalX returns the incoming w_valM/w_valE. Suppressed in HALTED.
- Undefined: read ports return stored contents only; decode forwarding covers same-cycle hazards.

## Structure
- Shared package: icode constants (IHALT…IPOPQ), RSP = 4, RNONE = 0xF, FSM state enum.
- One sub-module natural: wb_dst_decode (combinational icode/cnd/rA/rB → dstE/dstM), reused by the hazard unit.

## Test plan
- Reset, then irmovq (icode 3, rB=2, valE=0x1234) → next cycle d_srcA=2 reads 0x1234; retired = 1.
- popq %rsp (icode B, rA=4, valE=0x100, valM=0x200) → reg[4] = 0x200.
- cmovXX (icode 2, rB=3, valE=7) with w_cnd=0 → reg[3] unchanged; w_dstE = 0xF; with w_cnd=1 → reg[3] = 7.
- halt (icode 0) then OPq (icode 6, rB=1, valE=9) → halted=1 next cycle; reg[1] stays 0; retired frozen at its value after halt.
- Stream of 3 nops plus 2 OPq → retired = 2.
- With WB_BYPASS_EN: OPq rB=5 valE=0xAA while d_srcB=5 → d_rvalB=0xAA the same cycle; without the macro → old value. Reset pulsed mid-stream → all reads 0, halted 0 immediately.
